// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath and the key-schedule
// blocks.
//   AES_STATE_W / AES_COL_W : state and column widths
//   byte_t, col_idx_t       : byte and 2-bit column index types
//   isa_state_e             : control states of inv_sub_shift_addkey
//   inv_sbox()              : constant inverse S-box lookup
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_COL_W   = 32;

   typedef logic [7:0] byte_t;
   typedef logic [1:0] col_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } isa_state_e;

   // Entry 0x00 sits in the top byte, so entry b lives at [2047-8b -: 8].
   localparam logic [2047:0] INV_SBOX_ROM = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic byte_t inv_sbox(input byte_t b);
      return INV_SBOX_ROM[2047 - 8*int'(b) -: 8];
   endfunction

endpackage

// File: rtl/inv_sub_shift_addkey_if.sv
// Handshake bundle around inv_sub_shift_addkey.
// Valid/ready rule on both sides: a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds its payload and
// valid until that edge, and the receiver may raise or drop ready freely.
//   s_* : state/key/last from the round controller
//   m_* : processed state/last toward inverse MixColumns
// modport slave  : the block's view
// modport master : the controller's view
interface inv_sub_shift_addkey_if;
   import aes_pkg::*;

   logic                   s_valid;
   logic                   s_ready;
   logic [AES_STATE_W-1:0] s_state;
   logic [AES_STATE_W-1:0] s_key;
   logic                   s_last;
   logic                   m_valid;
   logic                   m_ready;
   logic [AES_STATE_W-1:0] m_state;
   logic                   m_last;

   modport slave (
      input  s_valid, s_state, s_key, s_last, m_ready,
      output s_ready, m_valid, m_state, m_last
   );

   modport master (
      output s_valid, s_state, s_key, s_last, m_ready,
      input  s_ready, m_valid, m_state, m_last
   );

endinterface

// File: rtl/inv_sbox_col.sv
// Four parallel inverse S-box lookups on one 32-bit column (combinational).
//   col_in  : column, row 0 in the top byte
//   col_out : InvSubBytes of col_in, same byte order
module inv_sbox_col
   import aes_pkg::*;
(
   input  logic [AES_COL_W-1:0] col_in,
   output logic [AES_COL_W-1:0] col_out
);

   always_comb begin
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
         col_out[AES_COL_W-1-8*r -: 8] = inv_sbox(col_in[AES_COL_W-1-8*r -: 8]);
      end
   end

endmodule

// File: rtl/inv_sub_shift_addkey.sv
// Column-serial AES decryption round front-end: InvShiftRows, InvSubBytes
// and AddRoundKey, one 32-bit output column per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : s_* input handshake, m_* output handshake (slave view)
//   dbg_state  : current control state
//   dbg_col    : column being written while busy
module inv_sub_shift_addkey
   import aes_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   inv_sub_shift_addkey_if.slave        bus,
   output isa_state_e                   dbg_state,
   output col_idx_t                     dbg_col
);

   isa_state_e             state_q, state_d;
   col_idx_t               col_q;
   logic [AES_STATE_W-1:0] in_state_q;
   logic [AES_STATE_W-1:0] in_key_q;
   logic                   in_last_q;
   logic [AES_STATE_W-1:0] out_state_q;
   logic                   out_last_q;

   logic                   s_ready;
   logic                   m_valid;
   logic                   accept;
   logic [AES_COL_W-1:0]   gather_col;
   logic [AES_COL_W-1:0]   sub_col;
   logic [AES_COL_W-1:0]   key_col;

   // Output row r of column col comes from input column (col - r); the
   // 2-bit subtraction wraps, which is exactly InvShiftRows.
   always_comb begin
      gather_col = '0;
      for (int r = 0; r < 4; r++) begin
         gather_col[AES_COL_W-1-8*r -: 8] =
            in_state_q[AES_STATE_W-1 - 32*int'(col_idx_t'(col_q - col_idx_t'(r))) - 8*r -: 8];
      end
   end

   assign key_col = in_key_q[AES_STATE_W-1 - 32*int'(col_q) -: 32];

   inv_sbox_col u_inv_sbox_col (
      .col_in  (gather_col),
      .col_out (sub_col)
   );

   // s_ready never looks at s_valid, so there is no s_valid->output path.
   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      m_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (bus.s_valid) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (col_q == 2'd3) state_d = ST_DONE;
         end
         ST_DONE: begin
            m_valid = 1'b1;
            // The output handshake frees the block, so a waiting input can
            // be taken on the same edge.
            s_ready = bus.m_ready;
            if (bus.m_ready) state_d = bus.s_valid ? ST_BUSY : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept = s_ready & bus.s_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         in_state_q  <= '0;
         in_key_q    <= '0;
         in_last_q   <= 1'b0;
         out_state_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            in_state_q <= bus.s_state;
            in_key_q   <= bus.s_key;
            in_last_q  <= bus.s_last;
            col_q      <= '0;
         end else if (state_q == ST_BUSY) begin
            out_state_q[AES_STATE_W-1 - 32*int'(col_q) -: 32] <= sub_col ^ key_col;
            col_q <= col_q + 2'd1;
            // m_last follows the state only once it is complete, so it is
            // stable for the whole time m_valid is high.
            if (col_q == 2'd3) out_last_q <= in_last_q;
         end
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_state = out_state_q;
   assign bus.m_last  = out_last_q;
   assign dbg_state   = state_q;
   assign dbg_col     = col_q;

endmodule
